// File: rtl/alu_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_if
// Description : Bundle of the two requester ports, the two response ports and
//               the shared-ALU port of alu_arb. The arbiter takes the slave
//               view; requesters and the ALU together take the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arb_if;
    logic        req0_vld;
    logic        req1_vld;
    logic        req0_rdy;
    logic        req1_rdy;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [2:0]  req0_op;
    logic [2:0]  req1_op;
    logic [3:0]  req0_ctl;
    logic [3:0]  req1_ctl;
    logic        rsp0_vld;
    logic        rsp1_vld;
    logic        rsp0_rdy;
    logic        rsp1_rdy;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_ctl;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;

    modport master (
        output req0_vld, req1_vld, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, req0_ctl, req1_ctl, rsp0_rdy, rsp1_rdy,
               alu_out, alu_flags,
        input  req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_data, rsp_flags,
               alu_a, alu_b, alu_op, alu_ctl
    );

    modport slave (
        input  req0_vld, req1_vld, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, req0_ctl, req1_ctl, rsp0_rdy, rsp1_rdy,
               alu_out, alu_flags,
        output req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_data, rsp_flags,
               alu_a, alu_b, alu_op, alu_ctl
    );
endinterface
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb
// Description : Two-port arbiter in front of a shared combinational ALU.
//               IDLE accepts one request, EXEC captures the ALU result,
//               RESP holds the result until the granted requester takes it.
//               Ties are resolved round-robin by default; defining
//               ALU_ARB_FIXED_PRIO_EN makes port 0 always win a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arb (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        gnt_sel;      // port picked this cycle if a request is taken
    logic        gnt_port;     // port owning the outstanding operation
    logic        tie_pick;     // winner when both ports request at once
    logic        accept;
    logic        capture;
    logic [1:0]  req_rdy;
    logic [1:0]  rsp_vld;
    logic [15:0] opnd_a;
    logic [15:0] opnd_b;
    logic [2:0]  opnd_op;
    logic [3:0]  opnd_ctl;
    logic [15:0] result_data;
    logic [4:0]  result_flags;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    logic last_gnt;

    // Remember the most recently accepted port; reset favours port 0 next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= gnt_sel;
        end
    end

    assign tie_pick = ~last_gnt;
`endif

    // A lone requester always wins; only a tie consults the priority rule.
    assign gnt_sel = (bus.req0_vld && bus.req1_vld) ? tie_pick : bus.req1_vld;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; handshakes are forced low during reset.
    always_comb begin
        state_nxt = state;
        req_rdy   = 2'b00;
        rsp_vld   = 2'b00;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (bus.req0_vld || bus.req1_vld)) begin
                    accept           = 1'b1;
                    req_rdy[gnt_sel] = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rst_n) begin
                    rsp_vld[gnt_port] = 1'b1;
                end
                if (gnt_port ? bus.rsp1_rdy : bus.rsp0_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Record which port owns the operation being served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_port <= 1'b0;
        end else if (accept) begin
            gnt_port <= gnt_sel;
        end
    end

    // Operand register: loaded from the granted port at accept, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opnd_a   <= '0;
            opnd_b   <= '0;
            opnd_op  <= '0;
            opnd_ctl <= '0;
        end else if (accept) begin
            if (gnt_sel) begin
                opnd_a   <= bus.req1_a;
                opnd_b   <= bus.req1_b;
                opnd_op  <= bus.req1_op;
                opnd_ctl <= bus.req1_ctl;
            end else begin
                opnd_a   <= bus.req0_a;
                opnd_b   <= bus.req0_b;
                opnd_op  <= bus.req0_op;
                opnd_ctl <= bus.req0_ctl;
            end
        end
    end

    // Result register: snapshot of the ALU during the single EXEC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_data  <= '0;
            result_flags <= '0;
        end else if (capture) begin
            result_data  <= bus.alu_out;
            result_flags <= bus.alu_flags;
        end
    end

    assign bus.req0_rdy  = req_rdy[0];
    assign bus.req1_rdy  = req_rdy[1];
    assign bus.rsp0_vld  = rsp_vld[0];
    assign bus.rsp1_vld  = rsp_vld[1];
    assign bus.rsp_data  = result_data;
    assign bus.rsp_flags = result_flags;
    assign bus.alu_a     = opnd_a;
    assign bus.alu_b     = opnd_b;
    assign bus.alu_op    = opnd_op;
    assign bus.alu_ctl   = opnd_ctl;
endmodule
`default_nettype wire
